dmem_load_arbiter: RTL

Parametrised data-memory port arbiter and boot loader between riscv_cpu's data port and data_mem. During a load session it accepts external words over a valid/ready handshake and buffers them in a small FIFO. It drains the FIFO into data memory at auto-incrementing word addresses while the CPU is held. After the load completes it releases the CPU and passes CPU data-port traffic, including store width, straight through.

---
 rtl/dmem_load_arbiter_if.sv | 40 ++++
 rtl/dmem_load_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_load_arbiter_if.sv
// Loader and data-memory port bundle for dmem_load_arbiter: external word stream,
// session control/status, CPU data port in, data_mem port out.
interface dmem_load_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 16
);
    logic              load_start;
    logic [LEN_W-1:0]  load_len;
    logic              ext_valid;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;
    logic              load_busy;
    logic              load_done;
    logic              cpu_hold;
    logic [LEN_W-1:0]  word_count;
    logic              cpu_memwrite;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;

    // Environment side: boot source, CPU data port and data_mem observer.
    modport master (
        output load_start, load_len, ext_valid, ext_data,
        output cpu_memwrite, cpu_addr, cpu_wdata, cpu_funct3,
        input  ext_ready, load_busy, load_done, cpu_hold, word_count,
        input  mem_we, mem_addr, mem_wdata, mem_funct3
    );

    modport slave (
        input  load_start, load_len, ext_valid, ext_data,
        input  cpu_memwrite, cpu_addr, cpu_wdata, cpu_funct3,
        output ext_ready, load_busy, load_done, cpu_hold, word_count,
        output mem_we, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/dmem_load_arbiter.sv
// Boot loader and data-memory port arbiter: buffers external words in a FIFO, drains them
// to data_mem at incrementing word addresses while the CPU is held, then passes CPU traffic.
module dmem_load_arbiter #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       LEN_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [2:0]        WORD_SEL   = 3'b010
) (
    input  logic                clk,
    input  logic                reset,
    dmem_load_arbiter_if.slave  bus
);
    localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]    wr_idx_q, wr_idx_d;
    logic [PTR_W:0]    rd_idx_q, rd_idx_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic busy;
    logic ready;
    logic push;
    logic pop;

    // Indices carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_idx_q == rd_idx_q);
    assign fifo_full  = (wr_idx_q[PTR_W] != rd_idx_q[PTR_W]) &&
                        (wr_idx_q[PTR_W-1:0] == rd_idx_q[PTR_W-1:0]);

    assign busy  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign ready = (state_q == ST_LOAD) && !fifo_full && (acc_q < len_q);
    assign push  = bus.ext_valid && ready;
    assign pop   = busy && !fifo_empty;

    assign bus.ext_ready  = ready;
    assign bus.load_busy  = busy;
    assign bus.load_done  = done_q;
    assign bus.cpu_hold   = (state_q != ST_RUN);
    assign bus.word_count = count_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d  = state_q;
        len_d    = len_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ptr_d    = ptr_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        done_d   = 1'b0;

        if (push) begin
            wr_idx_d = wr_idx_q + 1'b1;
            acc_d    = acc_q + 1'b1;
        end
        if (pop) begin
            rd_idx_d = rd_idx_q + 1'b1;
            count_d  = count_q + 1'b1;
            ptr_d    = ptr_q + ADDR_STEP;
        end

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                // A (re)load restarts the pointer and all counters.
                if (bus.load_start) begin
                    len_d    = bus.load_len;
                    acc_d    = '0;
                    count_d  = '0;
                    ptr_d    = BASE_ADDR;
                    wr_idx_d = '0;
                    rd_idx_d = '0;
                    if (bus.load_len != '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (push && (acc_d == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && (count_d == len_q)) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            ptr_q    <= BASE_ADDR;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ptr_q    <= ptr_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            done_q   <= done_d;
        end
    end

    // NOTE: FIFO storage is not reset; the indices alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_idx_q[PTR_W-1:0]] <= bus.ext_data;
        end
    end

    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_wdata  = bus.cpu_wdata;
        bus.mem_funct3 = bus.cpu_funct3;
        unique case (state_q)
            ST_LOAD, ST_DRAIN: begin
                bus.mem_we     = !fifo_empty;
                bus.mem_addr   = ptr_q;
                bus.mem_wdata  = fifo_mem[rd_idx_q[PTR_W-1:0]];
                bus.mem_funct3 = WORD_SEL;
            end
            ST_RUN: begin
                bus.mem_we = bus.cpu_memwrite;
            end
            default: ;
        endcase
    end
endmodule
